// File: rtl/commit_trace_fifo_if.sv
// Head-entry handshake bundle of the commit trace FIFO.
// The FIFO drives the master side and the trace consumer drives the slave side.
interface commit_trace_fifo_if;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [1:0]  Out_Type;
    logic [4:0]  Out_Reg;
    logic [31:0] Out_Data;
    logic [31:0] Out_PC;

    modport master (
        output Out_Valid,
        output Out_Type,
        output Out_Reg,
        output Out_Data,
        output Out_PC,
        input  Out_Ready
    );

    modport slave (
        input  Out_Valid,
        input  Out_Type,
        input  Out_Reg,
        input  Out_Data,
        input  Out_PC,
        output Out_Ready
    );
endinterface

// File: rtl/commit_trace_fifo.sv
// Commit trace FIFO: records retire events (REG/STORE/BRANCH/JUMP) with their PC.
// Define COMMIT_TRACE_SKIP_R0_EN to ignore register-0 writeback events.
module commit_trace_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Trace_En,
    input  logic                     WB_RegWrite,
    input  logic [4:0]               WB_WriteRegister,
    input  logic [31:0]              WB_WriteData,
    input  logic                     MEM_MemWrite,
    input  logic                     ID_BranchTaken,
    input  logic                     ID_DoJump,
    input  logic [31:0]              IF_PCResult,
    commit_trace_fifo_if.master      out,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Overflow,
    output logic [15:0]              Drop_Count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [1:0]  typ;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] pc;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [15:0]     drop_q, drop_d;

    logic            skip_r0;
    logic            event_v;
    logic            valid;
    logic            full;
    logic            pop;
    logic            push;
    logic            drop;
    entry_t          ev_entry;
    entry_t          head;

`ifdef COMMIT_TRACE_SKIP_R0_EN
    // An r0 write swallows the whole cycle, including lower-priority strobes.
    assign skip_r0 = WB_RegWrite && (WB_WriteRegister == 5'd0);
`else
    assign skip_r0 = 1'b0;
`endif

    assign event_v = Trace_En && !skip_r0 &&
                     (WB_RegWrite || MEM_MemWrite ||
                      ID_BranchTaken || ID_DoJump);

    assign valid = (count_q != '0);
    assign full  = (count_q == CW'(DEPTH));
    assign pop   = valid && out.Out_Ready;
    // A pop on the same edge frees the slot a full push needs.
    assign push  = event_v && (!full || pop);
    assign drop  = event_v && full && !pop;

    always_comb begin
        ev_entry = '0;
        ev_entry.pc = IF_PCResult;
        if (WB_RegWrite) begin
            ev_entry.typ  = 2'd0;
            ev_entry.rd   = WB_WriteRegister;
            ev_entry.data = WB_WriteData;
        end else if (MEM_MemWrite) begin
            ev_entry.typ = 2'd1;
        end else if (ID_BranchTaken) begin
            ev_entry.typ = 2'd2;
        end else begin
            ev_entry.typ = 2'd3;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        ovf_d    = ovf_q || drop;
        drop_d   = drop_q;
        if (drop && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset && push) begin
            mem_q[wr_ptr_q] <= ev_entry;
        end
    end

    assign head = mem_q[rd_ptr_q];

    always_comb begin
        out.Out_Valid = valid;
        out.Out_Type  = valid ? head.typ  : '0;
        out.Out_Reg   = valid ? head.rd   : '0;
        out.Out_Data  = valid ? head.data : '0;
        out.Out_PC    = valid ? head.pc   : '0;
    end

    assign Count      = count_q;
    assign Overflow   = ovf_q;
    assign Drop_Count = drop_q;
endmodule

// File: doc/commit_trace_fifo.md
COMMIT_TRACE_FIFO -- requirements
Module: commit_trace_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of trace entries (power of two, 2..256).
REQ-002 SHALL have port Clk  input  1  pipeline clock; all state updates on rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 SHALL have port Trace_En  input  1  capture enable.
REQ-005 SHALL have port WB_RegWrite  input  1  WB-stage register write strobe.
REQ-006 SHALL have port WB_WriteRegister  input  5  WB destination register.
REQ-007 SHALL have port WB_WriteData  input  32  WB write data.
REQ-008 SHALL have port MEM_MemWrite  input  1  MEM-stage store strobe.
REQ-009 SHALL have port ID_BranchTaken  input  1  ID-stage taken branch.
REQ-010 SHALL have port ID_DoJump  input  1  ID-stage jump.
REQ-011 SHALL have port IF_PCResult  input  32  current PC, recorded with each event.
REQ-012 SHALL have ports Out_Valid output 1, Out_Ready input 1: head-entry valid/ready handshake.
REQ-013 SHALL have ports Out_Type output 2 (0=REG,1=STORE,2=BRANCH,3=JUMP), Out_Reg output 5, Out_Data output 32, Out_PC output 32: head entry fields.
REQ-014 SHALL have ports Count output log2(DEPTH)+1 (occupancy), Overflow output 1 (sticky), Drop_Count output 16 (dropped events).

Function
REQ-015 Event exists in a cycle when Trace_En=1 and any of WB_RegWrite, MEM_MemWrite, ID_BranchTaken, ID_DoJump is 1.
REQ-016 Priority SHALL be REG > STORE > BRANCH > JUMP; at most one entry pushed per cycle.
REQ-017 REG entry: Reg=WB_WriteRegister, Data=WB_WriteData; other types: Reg=0, Data=0; PC=IF_PCResult for all types.
REQ-018 Push SHALL be sampled at rising edge N; entry visible on outputs after edge N (one-cycle latency), no combinational bypass.
REQ-019 Pop SHALL occur at rising edge when Out_Valid=1 and Out_Ready=1; next entry presented after that edge.
REQ-020 Out_Valid SHALL equal (Count != 0); Out_Type/Reg/Data/PC SHALL be 0 when Out_Valid=0.
REQ-021 Read/write pointers SHALL wrap modulo DEPTH.
REQ-022 Simultaneous push and pop when full SHALL accept the push (pop frees slot same edge); Count unchanged.
REQ-023 Simultaneous push and pop when empty: pop ignored (Out_Valid=0), push accepted, Count becomes 1.
REQ-024 Push when full without pop SHALL drop the event, set Overflow=1, increment Drop_Count saturating at 16'hFFFF.
REQ-025 Overflow SHALL remain 1 until reset; Out_Ready during overflow SHALL not clear it.
REQ-026 Trace_En=0 SHALL block pushes only; pops continue normally.

Reset
REQ-027 Reset=0 SHALL immediately clear pointers, Count=0, Out_Valid=0, Out_Type/Reg/Data/PC=0, Overflow=0, Drop_Count=0.
REQ-028 Reset mid-operation SHALL discard all stored entries; no event captured in any cycle whose edge sees Reset=0.
REQ-029 First capture SHALL be possible on the first rising edge after Reset deasserts.

Configuration
REQ-030 With COMMIT_TRACE_SKIP_R0_EN defined, REG events with WB_WriteRegister=0 SHALL be ignored entirely (no push, no drop count; lower-priority strobes in same cycle also ignored).
REQ-031 Without COMMIT_TRACE_SKIP_R0_EN, writes to register 0 SHALL be captured as normal REG entries.

Verification
REQ-032 Reset release, WB_RegWrite=1, reg 9, data 1, PC 4, Out_Ready=0 -> next cycle Out_Valid=1, Type=0, Reg=9, Data=1, PC=4, Count=1.
REQ-033 Same cycle WB_RegWrite=1 and ID_BranchTaken=1 -> exactly one REG entry, Count=1.
REQ-034 Out_Ready=0, 18 consecutive store events, DEPTH=16 -> Count=16, Overflow=1, Drop_Count=2; then drain 16 pops -> PCs in push order, Count=0, Overflow still 1.
REQ-035 Full FIFO, push+pop same edge -> Count stays 16, new entry appears last, Drop_Count unchanged.
REQ-036 Write to reg 0 with macro defined -> Count=0; without macro -> Count=1, Reg=0.
REQ-037 Reset=0 asserted mid-cycle with Count=5 -> Count=0, Out_Valid=0 immediately, before next clock edge.
